// File: rtl/bcd_digit_buffer_pkg.sv
// Shared constants, FSM state type and slot extraction for the BCD digit buffer.
package bcd_digit_buffer_pkg;

    localparam int unsigned N_SLOTS  = 16;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned N_DIGITS = 5;

    localparam int unsigned BUS_W   = N_SLOTS * DATA_W;
    localparam int unsigned SLOT_W  = $clog2(N_SLOTS);
    localparam int unsigned DIGIT_W = 3;
    localparam int unsigned BCD_W   = 4 * N_DIGITS;
    localparam int unsigned CNT_W   = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STORE = 2'd3
    } state_t;

    // Slot 0 sits in the most significant DATA_W bits of the packed bus.
    function automatic logic [DATA_W-1:0] slot_word(input logic [BUS_W-1:0] bus,
                                                    input logic [SLOT_W-1:0] idx);
        slot_word = bus[(N_SLOTS - 32'(idx)) * DATA_W - 1 -: DATA_W];
    endfunction

endpackage

// File: rtl/bcd_digit_buffer_dabble.sv
// One double-dabble iteration: add-3 correction of every nibble >= 5, then shift in one bit.
module bcd_dabble_step
    import bcd_digit_buffer_pkg::*;
(
    input  logic [BCD_W-1:0] acc,
    input  logic             bit_in,
    output logic [BCD_W-1:0] acc_c
);

    logic [BCD_W-1:0] corr;

    // Per-digit add-3 so the following shift carries correctly into the next decade.
    always_comb begin
        corr = acc;
        for (int d = 0; d < int'(N_DIGITS); d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                corr[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign acc_c = {corr[BCD_W-2:0], bit_in};

endmodule

// File: rtl/bcd_digit_buffer.sv
// Sweeps all packed counters through a double-dabble engine and serves BCD digits on a read port.
module bcd_digit_buffer
    import bcd_digit_buffer_pkg::*;
#(
    parameter bit AUTO = 1'b0
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [BUS_W-1:0]   data_in,
    input  logic               start,
    output logic               busy,
    output logic               sweep_done,
    input  logic [SLOT_W-1:0]  rd_slot,
    input  logic [DIGIT_W-1:0] rd_digit,
    output logic [3:0]         rd_bcd,
    output logic               rd_blank
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);

    state_t              state;
    state_t              state_next;
    logic [SLOT_W-1:0]   idx;
    logic [DATA_W-1:0]   shreg;
    logic [BCD_W-1:0]    acc;
    logic [BCD_W-1:0]    acc_step_c;
    logic [CNT_W-1:0]    cnt;
    logic [BCD_W-1:0]    digit_buf [N_SLOTS];
    logic [BCD_W-1:0]    rd_shifted_c;

    bcd_dabble_step u_step (
        .acc    (acc),
        .bit_in (shreg[DATA_W-1]),
        .acc_c  (acc_step_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start || AUTO) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST_BIT) state_next = ST_STORE;
            ST_STORE: state_next = (idx == LAST_SLOT) ? ST_IDLE : ST_LOAD;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Status flags, registered off the next state so busy rises with LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            busy       <= (state_next != ST_IDLE);
            sweep_done <= (state == ST_STORE) && (idx == LAST_SLOT);
        end
    end

    // Conversion datapath: snapshot, iterate, advance slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx   <= '0;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    shreg <= slot_word(data_in, idx);
                    acc   <= '0;
                    cnt   <= '0;
                end
                ST_SHIFT: begin
                    acc   <= acc_step_c;
                    shreg <= {shreg[DATA_W-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                end
                ST_STORE: begin
                    idx <= (idx == LAST_SLOT) ? '0 : idx + SLOT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Digit buffer: whole slot written at once in STORE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(N_SLOTS); s++) begin
                digit_buf[s] <= '0;
            end
        end else if (state == ST_STORE) begin
            digit_buf[idx] <= acc;
        end
    end

    // Shifting the slot word down puts the requested digit at [3:0] and leaves only higher digits above.
    assign rd_shifted_c = digit_buf[rd_slot] >> {rd_digit, 2'b00};

    // Registered read port; reads the pre-store contents when a store hits the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bcd   <= 4'd0;
            rd_blank <= 1'b0;
        end else if (rd_digit >= DIGIT_W'(N_DIGITS)) begin
            rd_bcd   <= 4'd0;
            rd_blank <= 1'b1;
        end else begin
            rd_bcd   <= rd_shifted_c[3:0];
            rd_blank <= (rd_digit != '0) && (rd_shifted_c == '0);
        end
    end

endmodule
